hazard_controller: RTL and testbench

Central hazard scheduler for the 5-stage pipelined MIPS core. It sequences the decode-stage datapath and surrounding pipeline registers.
- Generates decode-stage forwarding selects (ForwardAD/ForwardBD) and execute-stage forwarding selects.
- Generates stall and flush controls for load-use, branch-compare and multiply/divide-unit (MDU) hazards.
- Owns the MDU busy-sequencing FSM and a saturating stall-cycle performance counter.

---
 rtl/hazard_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard scheduler for the 5-stage MIPS pipeline: forwarding selects, stall/flush
// generation, MDU busy sequencing and a saturating stall-cycle counter.
module hazard_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             MduUseD,
    input  logic             MduStartE,
    input  logic             MduOpE,
    input  logic             CntClr,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MduBusy,
    output logic             MduDone,
    output logic [CNT_W-1:0] StallCount
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW_RAW  = $clog2(MAX_CYC);
    localparam int CW      = (CW_RAW > 6) ? CW_RAW : 6;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

    mdu_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic              done_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic [1:0] fwd_ae;
    logic [1:0] fwd_be;
    logic       lwstall;
    logic       brstall;
    logic       mdustall;
    logic       stall_raw;
    logic       stall;

    // Register $0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        fwd_ae = 2'b00;
        if (RegWriteM && reg_match(WriteRegM, RsE))
            fwd_ae = 2'b10;
        else if (RegWriteW && reg_match(WriteRegW, RsE))
            fwd_ae = 2'b01;

        fwd_be = 2'b00;
        if (RegWriteM && reg_match(WriteRegM, RtE))
            fwd_be = 2'b10;
        else if (RegWriteW && reg_match(WriteRegW, RtE))
            fwd_be = 2'b01;
    end

    assign lwstall  = MemtoRegE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));
    assign brstall  = BranchD &&
                      ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                       (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    assign mdustall = MduUseD && ((state_q == BUSY) || MduStartE);
    assign stall_raw = lwstall || brstall || mdustall;

    // Every combinational output is held low while reset is asserted.
    assign stall     = rst && stall_raw;
    assign ForwardAE = rst ? fwd_ae : 2'b00;
    assign ForwardBE = rst ? fwd_be : 2'b00;
    assign ForwardAD = rst && RegWriteM && reg_match(WriteRegM, RsD);
    assign ForwardBD = rst && RegWriteM && reg_match(WriteRegM, RtD);
    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign FlushD    = rst && PCSrcD && !stall_raw;
    assign MduBusy   = rst && (state_q == BUSY);
    assign MduDone   = done_q;

    // A start seen while BUSY is ignored; the decode stall keeps it from happening in practice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MduStartE) begin
                        state_q <= BUSY;
                        cnt_q   <= MduOpE ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (CntClr)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expectations are queued as stimulus is
// applied and compared against the outputs at the following falling edge.
module tb_hazard_controller;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       RsD, RtD, RsE, RtE;
    logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM;
    logic             BranchD, PCSrcD, MduUseD, MduStartE, MduOpE, CntClr;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic             MduBusy, MduDone;
    logic [CNT_W-1:0] StallCount;

    hazard_controller #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MduUseD(MduUseD),
        .MduStartE(MduStartE), .MduOpE(MduOpE), .CntClr(CntClr),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MduBusy(MduBusy), .MduDone(MduDone), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_FAE = 0, S_FBE = 1, S_FAD = 2, S_FBD = 3, S_STF = 4, S_STD = 5;
    localparam int S_FLD = 6, S_FLE = 7, S_BSY = 8, S_DON = 9, S_CNT = 10;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("chk  %s: %0h ok", tag, obs);
        end
    endtask

    function automatic logic [31:0] obs_sig(input int s);
        case (s)
            S_FAE:   return {30'd0, ForwardAE};
            S_FBE:   return {30'd0, ForwardBE};
            S_FAD:   return {31'd0, ForwardAD};
            S_FBD:   return {31'd0, ForwardBD};
            S_STF:   return {31'd0, StallF};
            S_STD:   return {31'd0, StallD};
            S_FLD:   return {31'd0, FlushD};
            S_FLE:   return {31'd0, FlushE};
            S_BSY:   return {31'd0, MduBusy};
            S_DON:   return {31'd0, MduDone};
            default: return {28'd0, StallCount};
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, obs_sig(e.sig), e.exp);
        end
    endtask

    task automatic expect_stall(input string tag, input bit s, input bit fd);
        push({tag, ".StallF"}, S_STF, {31'd0, s});
        push({tag, ".StallD"}, S_STD, {31'd0, s});
        push({tag, ".FlushE"}, S_FLE, {31'd0, s});
        push({tag, ".FlushD"}, S_FLD, {31'd0, fd});
    endtask

    task automatic expect_all_zero(input string tag);
        for (int s = S_FAE; s <= S_CNT; s++)
            push($sformatf("%s.sig%0d", tag, s), s, 32'd0);
    endtask

    task automatic clr_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; PCSrcD = 1'b0; MduUseD = 1'b0;
        MduStartE = 1'b0; MduOpE = 1'b0; CntClr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare at the falling edge, then cross one rising edge and update the counter model.
    task automatic run_cycle(input string tag, input bit stall_exp, input bit clr);
        push({tag, ".StallCount"}, S_CNT, exp_cnt);
        @(negedge clk);
        drain();
        cyc();
        if (clr)
            exp_cnt = 0;
        else if (stall_exp && exp_cnt < (1 << CNT_W) - 1)
            exp_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_len;

        // Reset with hazardous inputs applied: everything must stay low.
        clr_inputs();
        rst = 1'b0;
        RsE = 5; RegWriteM = 1'b1; WriteRegM = 5;
        MemtoRegE = 1'b1; WriteRegE = 8; RtD = 8; PCSrcD = 1'b1;
        MduStartE = 1'b1; MduUseD = 1'b1;
        #3;
        expect_all_zero("reset");
        drain();
        @(negedge clk);
        clr_inputs();
        rst = 1'b1;
        cyc();

        // Forwarding priority and $0 exclusion
        RsE = 5; RegWriteM = 1'b1; WriteRegM = 5; RegWriteW = 1'b1; WriteRegW = 5;
        push("fwd_m.AE", S_FAE, 32'd2);
        push("fwd_m.BE", S_FBE, 32'd0);
        expect_stall("fwd_m", 1'b0, 1'b0);
        run_cycle("fwd_m", 1'b0, 1'b0);
        RegWriteM = 1'b0;
        push("fwd_w.AE", S_FAE, 32'd1);
        run_cycle("fwd_w", 1'b0, 1'b0);
        RsE = 0; RegWriteM = 1'b1; WriteRegM = 0; WriteRegW = 0;
        push("fwd_r0.AE", S_FAE, 32'd0);
        run_cycle("fwd_r0", 1'b0, 1'b0);
        RtE = 7; WriteRegW = 7; WriteRegM = 9;
        push("fwd_bw.BE", S_FBE, 32'd1);
        push("fwd_bw.AE", S_FAE, 32'd0);
        run_cycle("fwd_bw", 1'b0, 1'b0);

        // Load-use
        clr_inputs();
        MemtoRegE = 1'b1; WriteRegE = 8; RtD = 8; PCSrcD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_stall($sformatf("lw%0d", i), 1'b1, 1'b0);
            run_cycle($sformatf("lw%0d", i), 1'b1, 1'b0);
        end
        WriteRegE = 0; RtD = 0; RsD = 0;
        expect_stall("lw_r0", 1'b0, 1'b1);
        run_cycle("lw_r0", 1'b0, 1'b0);

        // Branch compare hazards
        clr_inputs();
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 3; RsD = 3; PCSrcD = 1'b1;
        expect_stall("br_e", 1'b1, 1'b0);
        run_cycle("br_e", 1'b1, 1'b0);
        RegWriteE = 1'b0; RegWriteM = 1'b1; WriteRegM = 3;
        expect_stall("br_ok", 1'b0, 1'b1);
        push("br_ok.AD", S_FAD, 32'd1);
        push("br_ok.BD", S_FBD, 32'd0);
        run_cycle("br_ok", 1'b0, 1'b0);
        MemtoRegM = 1'b1;
        expect_stall("br_ld", 1'b1, 1'b0);
        run_cycle("br_ld", 1'b1, 1'b0);

        // Multiply: start cycle plus four busy cycles all stall D
        clr_inputs();
        MduUseD = 1'b1; MduStartE = 1'b1; MduOpE = 1'b0;
        push("mul_st.Busy", S_BSY, 32'd0);
        expect_stall("mul_st", 1'b1, 1'b0);
        run_cycle("mul_st", 1'b1, 1'b0);
        MduStartE = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("mul_b%0d.Busy", k), S_BSY, 32'd1);
            push($sformatf("mul_b%0d.Done", k), S_DON, 32'd0);
            expect_stall($sformatf("mul_b%0d", k), 1'b1, 1'b0);
            run_cycle($sformatf("mul_b%0d", k), 1'b1, 1'b0);
        end
        push("mul_end.Busy", S_BSY, 32'd0);
        push("mul_end.Done", S_DON, 32'd1);
        expect_stall("mul_end", 1'b0, 1'b0);
        run_cycle("mul_end", 1'b0, 1'b0);
        push("mul_post.Done", S_DON, 32'd0);
        run_cycle("mul_post", 1'b0, 1'b0);

        // Divide, with a stray multiply start mid-operation that must not reload
        clr_inputs();
        MduStartE = 1'b1; MduOpE = 1'b1;
        push("div_st.Busy", S_BSY, 32'd0);
        run_cycle("div_st", 1'b0, 1'b0);
        MduStartE = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!MduBusy) break;
            busy_len++;
            @(posedge clk);
            #1;
            MduStartE = (busy_len == 5);
            MduOpE = 1'b0;
        end
        MduStartE = 1'b0;
        check_val("div_busy_len", busy_len, 32'd32);
        push("div_end.Done", S_DON, 32'd1);
        drain();
        cyc();
        push("div_post.Done", S_DON, 32'd0);
        run_cycle("div_post", 1'b0, 1'b0);

        // Counter saturation and clear priority
        clr_inputs();
        MemtoRegE = 1'b1; WriteRegE = 8; RtD = 8;
        for (int i = 0; i < 20; i++)
            run_cycle($sformatf("sat%0d", i), 1'b1, 1'b0);
        CntClr = 1'b1;
        run_cycle("clr", 1'b1, 1'b1);
        CntClr = 1'b0;
        run_cycle("clr_after", 1'b1, 1'b0);
        clr_inputs();
        run_cycle("clr_idle", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a divide (cnt = 10)
        clr_inputs();
        MduStartE = 1'b1; MduOpE = 1'b1;
        run_cycle("rdiv_st", 1'b0, 1'b0);
        MduStartE = 1'b0;
        repeat (21) cyc();
        push("rdiv_mid.Busy", S_BSY, 32'd1);
        @(negedge clk);
        drain();
        #2;
        RsE = 5; RegWriteM = 1'b1; WriteRegM = 5;
        MemtoRegE = 1'b1; WriteRegE = 8; RtD = 8; PCSrcD = 1'b1; MduUseD = 1'b1;
        rst = 1'b0;
        #1;
        expect_all_zero("rst_async");
        drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            push($sformatf("rst_hold%0d.Done", i), S_DON, 32'd0);
            push($sformatf("rst_hold%0d.Busy", i), S_BSY, 32'd0);
            push($sformatf("rst_hold%0d.StallD", i), S_STD, 32'd0);
            push($sformatf("rst_hold%0d.AE", i), S_FAE, 32'd0);
            drain();
        end
        clr_inputs();
        rst = 1'b1;
        exp_cnt = 0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            push($sformatf("post_rst%0d.Busy", i), S_BSY, 32'd0);
            push($sformatf("post_rst%0d.Done", i), S_DON, 32'd0);
            run_cycle($sformatf("post_rst%0d", i), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
